// File: rtl/ysyx_24100029_gshare_ctrl.sv
// Gshare requester: builds PHT read indices from PC xor speculative history,
// tracks in-flight predictions in a checkpoint FIFO and issues PHT updates on resolution.
module ysyx_24100029_gshare_ctrl #(
  parameter int PHT_INDEX_WIDTH = 8,
  parameter int GHR_WIDTH       = 8,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         pred_valid,
  output logic                         pred_ready,
  input  logic [31:0]                  pred_pc,
  output logic [PHT_INDEX_WIDTH-1:0]   pht_index_r,
  input  logic                         pht_state,
  output logic                         pred_taken,
  input  logic                         res_valid,
  input  logic                         res_taken,
  input  logic                         res_mispredict,
  output logic                         pht_w_en,
  output logic [PHT_INDEX_WIDTH-1:0]   pht_index_w,
  output logic                         is_taken,
  output logic [$clog2(FIFO_DEPTH):0]  outstanding,
  output logic [GHR_WIDTH-1:0]         ghr_spec,
  output logic                         err_underflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  // Handshake: a prediction is taken on pred_valid && pred_ready at the rising
  // clock edge; pred_valid may be held across cycles and pred_ready never waits on it.
  logic [GHR_WIDTH-1:0]       ghr_q, ghr_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [PW-1:0]              wr_q, wr_d, rd_q, rd_d;
  logic                       w_en_q, w_en_d;
  logic [PHT_INDEX_WIDTH-1:0] widx_q, widx_d;
  logic                       taken_q, taken_d;
  logic                       err_q, err_d;

  // Only the low GHR_WIDTH-1 bits of a snapshot matter: restore shifts out the MSB.
  logic [PHT_INDEX_WIDTH-1:0] idx_mem [FIFO_DEPTH];
  logic [GHR_WIDTH-2:0]       ghr_mem [FIFO_DEPTH];

  logic [PHT_INDEX_WIDTH-1:0] ghr_ext;
  logic                       empty, accept, pop, flush;
  logic                       unused_pc;

  assign unused_pc = ^{pred_pc[31:PHT_INDEX_WIDTH+2], pred_pc[1:0]};

  always_comb begin
    ghr_ext = '0;
    ghr_ext[GHR_WIDTH-1:0] = ghr_q;
  end

  assign empty       = (cnt_q == '0);
  assign pht_index_r = pred_pc[PHT_INDEX_WIDTH+1:2] ^ ghr_ext;
  assign pred_taken  = pht_state;
  assign pred_ready  = (cnt_q != CW'(FIFO_DEPTH)) && !(res_valid && res_mispredict);
  assign accept      = pred_valid && pred_ready;
  assign pop         = res_valid && !empty;
  assign flush       = pop && res_mispredict;

  always_comb begin
    ghr_d   = ghr_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    err_d   = err_q | (res_valid && empty);
    w_en_d  = pop;
    widx_d  = pop ? idx_mem[rd_q] : widx_q;
    taken_d = pop ? res_taken : taken_q;
    if (flush) begin
      ghr_d = {ghr_mem[rd_q], res_taken};
      cnt_d = '0;
      wr_d  = '0;
      rd_d  = '0;
    end else begin
      if (accept) begin
        wr_d  = wr_q + 1'b1;
        ghr_d = {ghr_q[GHR_WIDTH-2:0], pht_state};
      end
      if (pop) rd_d = rd_q + 1'b1;
      if (accept && !pop)      cnt_d = cnt_q + 1'b1;
      else if (!accept && pop) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ghr_q   <= '0;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      w_en_q  <= 1'b0;
      widx_q  <= '0;
      taken_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ghr_q   <= ghr_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      w_en_q  <= w_en_d;
      widx_q  <= widx_d;
      taken_q <= taken_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      idx_mem[wr_q] <= pht_index_r;
      ghr_mem[wr_q] <= ghr_q[GHR_WIDTH-2:0];
    end
  end

  // A pending update is dropped as soon as reset is raised, not one cycle later.
  assign pht_w_en      = w_en_q && !reset;
  assign pht_index_w   = widx_q;
  assign is_taken      = taken_q;
  assign outstanding   = cnt_q;
  assign ghr_spec      = ghr_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_ysyx_24100029_gshare_ctrl.sv
// Bench for the gshare controller: directed scenarios with fixed expectations,
// then random traffic against a queue-based reference model.
module tb_ysyx_24100029_gshare_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        pred_valid, pred_ready;
  logic [31:0] pred_pc;
  logic [7:0]  pht_index_r;
  logic        pht_state, pred_taken;
  logic        res_valid, res_taken, res_mispredict;
  logic        pht_w_en;
  logic [7:0]  pht_index_w;
  logic        is_taken;
  logic [2:0]  outstanding;
  logic [7:0]  ghr_spec;
  logic        err_underflow;

  always #5 clock = ~clock;

  ysyx_24100029_gshare_ctrl #(.PHT_INDEX_WIDTH(8), .GHR_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_pc(pred_pc),
    .pht_index_r(pht_index_r), .pht_state(pht_state), .pred_taken(pred_taken),
    .res_valid(res_valid), .res_taken(res_taken), .res_mispredict(res_mispredict),
    .pht_w_en(pht_w_en), .pht_index_w(pht_index_w), .is_taken(is_taken),
    .outstanding(outstanding), .ghr_spec(ghr_spec), .err_underflow(err_underflow)
  );

  // Reference model: each in-flight prediction is {index, history snapshot}.
  logic [15:0] exp_q[$];
  logic [7:0]  m_ghr;
  logic        m_wen, m_taken, m_err;
  logic [7:0]  m_widx;
  int          n_cmp = 0;
  int          n_fail = 0;

  localparam logic [31:0] PC0 = 32'h8000_0010;

  function automatic logic [7:0] m_index();
    return pred_pc[9:2] ^ m_ghr;
  endfunction

  function automatic logic m_ready();
    return (exp_q.size() != 4) && !(res_valid && res_mispredict);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_ghr = 8'h00; m_wen = 1'b0; m_widx = 8'h00; m_taken = 1'b0; m_err = 1'b0;
  endtask

  task automatic drive(input logic rst, input logic pv, input logic [31:0] pc, input logic ps,
                       input logic rv, input logic rt, input logic rm);
    reset = rst; pred_valid = pv; pred_pc = pc; pht_state = ps;
    res_valid = rv; res_taken = rt; res_mispredict = rm;
    #1;
  endtask

  // Advances one clock and the model with it; leaves time 1 unit past the edge.
  task automatic tick();
    logic        acc, pop;
    logic [15:0] head;
    logic [7:0]  idx;
    idx  = m_index();
    acc  = pred_valid && m_ready();
    pop  = res_valid && (exp_q.size() > 0);
    head = pop ? exp_q[0] : 16'h0;
    @(posedge clock);
    if (reset) begin
      model_reset();
    end else begin
      m_wen = pop;
      if (pop) begin m_widx = head[15:8]; m_taken = res_taken; end
      if (res_valid && exp_q.size() == 0) m_err = 1'b1;
      if (pop && res_mispredict) begin
        m_ghr = {head[6:0], res_taken};
        exp_q.delete();
      end else begin
        if (pop) void'(exp_q.pop_front());
        if (acc) begin
          exp_q.push_back({idx, m_ghr});
          m_ghr = {m_ghr[6:0], pht_state};
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (ghr_spec !== 8'h00) begin n_fail++; $display("FAIL reset_ghr: got %h want 00", ghr_spec); end
    n_cmp++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
    n_cmp++; if (pht_w_en !== 1'b0) begin n_fail++; $display("FAIL reset_wen: got %b want 0", pht_w_en); end
    n_cmp++; if ({pht_index_w, is_taken} !== 9'h0) begin n_fail++; $display("FAIL reset_upd: got %h/%b want 00/0", pht_index_w, is_taken); end
    n_cmp++; if (err_underflow !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_underflow); end
    n_cmp++; if (pred_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", pred_ready); end
  endtask

  task automatic test_fill_and_resolve();
    drive(1'b0, 1'b1, PC0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (pht_index_r !== 8'h04) begin n_fail++; $display("FAIL fill_idx0: got %h want 04", pht_index_r); end
    n_cmp++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL fill_taken: got %b want 1", pred_taken); end
    tick();
    n_cmp++; if (ghr_spec !== 8'h01 || outstanding !== 3'd1) begin n_fail++; $display("FAIL fill_1: got ghr %h out %0d want 01/1", ghr_spec, outstanding); end
    drive(1'b0, 1'b1, PC0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (pht_index_r !== 8'h05) begin n_fail++; $display("FAIL fill_idx1: got %h want 05", pht_index_r); end
    tick();
    n_cmp++; if (ghr_spec !== 8'h03 || outstanding !== 3'd2) begin n_fail++; $display("FAIL fill_2: got ghr %h out %0d want 03/2", ghr_spec, outstanding); end
    tick();
    tick();
    n_cmp++; if (ghr_spec !== 8'h0f || outstanding !== 3'd4) begin n_fail++; $display("FAIL fill_4: got ghr %h out %0d want 0f/4", ghr_spec, outstanding); end
    n_cmp++; if (pred_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", pred_ready); end
    drive(1'b0, 1'b0, PC0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    n_cmp++; if ({pht_w_en, pht_index_w, is_taken} !== {1'b1, 8'h04, 1'b1}) begin n_fail++; $display("FAIL resolve_upd: got %b/%h/%b want 1/04/1", pht_w_en, pht_index_w, is_taken); end
    n_cmp++; if (outstanding !== 3'd3 || pred_ready !== 1'b1) begin n_fail++; $display("FAIL resolve_cnt: got out %0d rdy %b want 3/1", outstanding, pred_ready); end
    drive(1'b0, 1'b0, PC0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    n_cmp++; if ({pht_w_en, pht_index_w, is_taken} !== {1'b0, 8'h04, 1'b1}) begin n_fail++; $display("FAIL upd_hold: got %b/%h/%b want 0/04/1", pht_w_en, pht_index_w, is_taken); end
  endtask

  task automatic test_mispredict();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, PC0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    n_cmp++; if (ghr_spec !== 8'h07 || outstanding !== 3'd3) begin n_fail++; $display("FAIL mp_setup: got ghr %h out %0d want 07/3", ghr_spec, outstanding); end
    drive(1'b0, 1'b1, PC0, 1'b1, 1'b1, 1'b0, 1'b1);
    n_cmp++; if (pred_ready !== 1'b0) begin n_fail++; $display("FAIL mp_ready: got %b want 0", pred_ready); end
    tick();
    n_cmp++; if (ghr_spec !== 8'h00 || outstanding !== 3'd0) begin n_fail++; $display("FAIL mp_flush: got ghr %h out %0d want 00/0", ghr_spec, outstanding); end
    n_cmp++; if ({pht_w_en, pht_index_w, is_taken} !== {1'b1, 8'h04, 1'b0}) begin n_fail++; $display("FAIL mp_upd: got %b/%h/%b want 1/04/0", pht_w_en, pht_index_w, is_taken); end
  endtask

  task automatic test_underflow();
    drive(1'b0, 1'b0, PC0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    n_cmp++; if (err_underflow !== 1'b1 || pht_w_en !== 1'b0) begin n_fail++; $display("FAIL uf_set: got err %b wen %b want 1/0", err_underflow, pht_w_en); end
    n_cmp++; if (ghr_spec !== 8'h00 || outstanding !== 3'd0) begin n_fail++; $display("FAIL uf_state: got ghr %h out %0d want 00/0", ghr_spec, outstanding); end
    drive(1'b0, 1'b1, PC0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    n_cmp++; if (err_underflow !== 1'b1 || outstanding !== 3'd1) begin n_fail++; $display("FAIL uf_sticky: got err %b out %0d want 1/1", err_underflow, outstanding); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1'b0, 1'b1, PC0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, PC0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 1'b0, PC0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (pht_w_en !== 1'b0) begin n_fail++; $display("FAIL rmid_wen: got %b want 0", pht_w_en); end
    tick();
    n_cmp++; if (outstanding !== 3'd0 || ghr_spec !== 8'h00 || pht_w_en !== 1'b0) begin n_fail++; $display("FAIL rmid_state: got out %0d ghr %h wen %b want 0/00/0", outstanding, ghr_spec, pht_w_en); end
    drive(1'b0, 1'b0, PC0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic        rst, pv, ps, rv, rt, rm;
    logic [31:0] pc;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      pv  = $urandom_range(0, 2) != 0;
      pc  = $urandom;
      ps  = $urandom_range(0, 1);
      rv  = $urandom_range(0, 2) == 0;
      rt  = $urandom_range(0, 1);
      rm  = rv && ($urandom_range(0, 4) == 0);
      drive(rst, pv, pc, ps, rv, rt, rm);
      n_cmp++; if (pht_index_r !== m_index()) begin n_fail++; $display("FAIL rnd_idx[%0d]: got %h want %h", i, pht_index_r, m_index()); end
      n_cmp++; if (pred_ready !== m_ready()) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, pred_ready, m_ready()); end
      tick();
      n_cmp++; if (ghr_spec !== m_ghr) begin n_fail++; $display("FAIL rnd_ghr[%0d]: got %h want %h", i, ghr_spec, m_ghr); end
      n_cmp++; if (outstanding !== 3'(exp_q.size())) begin n_fail++; $display("FAIL rnd_out[%0d]: got %0d want %0d", i, outstanding, exp_q.size()); end
      n_cmp++; if (pht_w_en !== (m_wen && !reset)) begin n_fail++; $display("FAIL rnd_wen[%0d]: got %b want %b", i, pht_w_en, m_wen && !reset); end
      n_cmp++; if ({pht_index_w, is_taken} !== {m_widx, m_taken}) begin n_fail++; $display("FAIL rnd_upd[%0d]: got %h/%b want %h/%b", i, pht_index_w, is_taken, m_widx, m_taken); end
      n_cmp++; if (err_underflow !== m_err) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b want %b", i, err_underflow, m_err); end
    end
  endtask

  initial begin
    reset = 1'b1; pred_valid = 1'b0; pred_pc = '0; pht_state = 1'b0;
    res_valid = 1'b0; res_taken = 1'b0; res_mispredict = 1'b0;
    model_reset();
    test_reset();
    test_fill_and_resolve();
    test_mispredict();
    test_underflow();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
